// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: NCH producer channels in, one consumer out.
// The master side is the surrounding system; the slave side is the mux.
interface stream_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with fixed-select or round-robin grant, one output
// register stage and full valid/ready back-pressure.
module stream_mux_rr_lane #(
    parameter int WIDTH = 4,
    parameter int SELW  = 2,
    parameter int LANE  = 0
) (
    input  logic             load_en,
    input  logic             gnt_vld,
    input  logic [SELW-1:0]  gnt,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] data_gated
);
    assign ready      = load_en && gnt_vld && (gnt == SELW'(LANE));
    assign data_gated = ready ? data : '0;
endmodule

module stream_mux_rr #(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus,
    input  logic            mode,
    input  logic [SELW-1:0] sel
);
    localparam int SELN = 1 << SELW;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  ch;
    } beat_t;

    beat_t                      out_q;
    logic                       out_valid_q;
    logic [SELW-1:0]            ptr;

    logic                       load_en;
    logic [SELN-1:0]            vld_pad;
    logic                       fx_vld;
    logic                       rr_vld;
    logic [SELW-1:0]            rr_gnt;
    logic                       gnt_vld;
    logic [SELW-1:0]            gnt;
    logic [NCH-1:0]             ready;
    logic [NCH-1:0][WIDTH-1:0]  lane_data;
    logic [WIDTH-1:0]           mux_data;
    logic                       transfer;
    int                         idx;

    // rst_n gates load_en so no producer sees ready while reset is held.
    assign load_en = rst_n && (!out_valid_q || bus.out_ready);

    // Padding to the full select range makes out-of-range sel read as invalid.
    assign vld_pad = SELN'(bus.in_valid);
    assign fx_vld  = vld_pad[sel];

    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        idx    = 0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NCH) idx = idx - NCH;
            if (!rr_vld && vld_pad[SELW'(idx)]) begin
                rr_vld = 1'b1;
                rr_gnt = SELW'(idx);
            end
        end
    end

    assign gnt_vld = mode ? rr_vld : fx_vld;
    assign gnt     = mode ? rr_gnt : sel;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        stream_mux_rr_lane #(
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .LANE  (k)
        ) u_lane (
            .load_en    (load_en),
            .gnt_vld    (gnt_vld),
            .gnt        (gnt),
            .data       (bus.in_data[k*WIDTH +: WIDTH]),
            .ready      (ready[k]),
            .data_gated (lane_data[k])
        );
    end

    // At most one lane is ready, so an OR tree is the data mux.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NCH; k++) mux_data = mux_data | lane_data[k];
    end

    assign transfer     = |ready;
    assign bus.in_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ptr         <= '0;
        end else begin
            if (load_en) begin
                out_valid_q <= transfer;
                if (transfer) out_q <= '{data: mux_data, ch: gnt};
            end
            if (transfer && mode)
                ptr <= (gnt == SELW'(NCH-1)) ? '0 : gnt + 1'b1;
        end
    end

    assign bus.out_data  = out_q.data;
    assign bus.out_ch    = out_q.ch;
    assign bus.out_valid = out_valid_q;
endmodule
